conv_mac_pipe: RTL and testbench
================================

# conv_mac_pipe

Parametrised, pipelined signed multiply / multiply-accumulate unit for the convolution datapath, the successor to the fixed 16×8→24 combinational multiplier instances. A per-beat mode selects plain multiply (one result per beat) or accumulate (one result per group, closed by `in_last`). It sits between the window/weight fetch logic and the output write-back stage, under HLS-style clock-enable control.

## Interface
- `NUM_STAGE`, 2: product pipeline registers, ≥1.
- `din0_WIDTH`, 16: signed operand A width.
- `din1_WIDTH`, 8: signed operand B width.
- `ACC_WIDTH`, 32: signed accumulator width, ≥ din0_WIDTH+din1_WIDTH.
- `dout_WIDTH`, 24: signed result width, ≤ ACC_WIDTH.
- `SATURATE`, 0: 1 = saturate result to dout range; 0 = two's-complement truncation (keep LSBs).
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; 0 freezes every register.
- `in_valid`  in  1  beat present on din0/din1.
- `in_mode`  in  1  0 = multiply, 1 = accumulate.
- `in_last`  in  1  closes the accumulate group; ignored when in_mode=0.
- `din0`  in  din0_WIDTH  signed operand A.
- `din1`  in  din1_WIDTH  signed operand B.
- `out_valid`  out  1  dout holds a new result this cycle.
- `dout`  out  dout_WIDTH  signed result.

## Operation
- Beat accepted on a rising edge with ce=1 and in_valid=1; no backpressure, a beat accepted every cycle.
- Full-precision signed product P (din0_WIDTH+din1_WIDTH bits) through NUM_STAGE registers; valid, mode, last travel alongside.
- Final stage, per product beat arriving with ce=1:
  - mode 0: result = sign-extended P; out_valid=1; accumulator untouched.
  - mode 1, last=0: acc ← acc+P (ACC_WIDTH, wraps); out_valid=0.
  - mode 1, last=1: result = acc+P; out_valid=1; acc ← 0.
- Result→dout: SATURATE=1 clamps to [−2^(dout_WIDTH−1), 2^(dout_WIDTH−1)−1]; else LSBs.
- Mode-0 beats interleaved in an open group do not disturb the group.
- Accumulator wraps silently in ACC_WIDTH; saturation applies only on the output conversion.

## Timing
- Latency: beat accepted at edge k → out_valid/dout at edge k+NUM_STAGE+1 (ce=1 throughout). Throughput 1 beat/cycle.
- out_valid is a single-cycle pulse per result when ce=1; with ce=0 dout and out_valid hold their values.
- ce=0: no beat accepted, pipeline, acc, out_valid, dout all frozen; resume exactly where paused.
- Reset (async assert, any cycle): all pipeline valids 0, acc 0, out_valid 0, dout 0; in-flight beats and any open group discarded. First beat after deassertion is processed normally.
- in_last with in_mode=1 on the first beat of a group: single-beat group, dout = saturated/truncated P.

## Structure
- Package `conv_mac_pkg`: mode constants (MODE_MUL=0, MODE_ACC=1), saturate/truncate function parametrised by widths.
- Sub-module `conv_mac_mul_pipe`: signed multiplier + NUM_STAGE register chain carrying valid/mode/last sidebands with ce; suitable for DSP inference (retimed across stages).
- Top `conv_mac_pipe`: accumulator, output conversion, output registers.

## Test plan
- Reset: assert reset mid-stream, check out_valid=0, dout=0 immediately (asynchronous); after release no stale result ever emerges.
- Multiply (defaults): din0=−32768, din1=−128, mode 0 → dout=4194304 at edge k+3; back-to-back din0=32767,din1=127 → 4161409 next cycle.
- Accumulate: four beats din0=1000, din1=100, last on 4th → single out_valid, dout=400000; a mode-0 beat 7×−3 inserted mid-group → dout=−21 without altering the 400000.
- Saturation: three beats 32767×127 with last on 3rd; SATURATE=1 → dout=8388607; SATURATE=0 → dout=−4292989. Likewise −32768×127 ×3, SATURATE=1 → −8388608.
- Stall: ce=0 for 5 cycles while two beats are in flight → outputs frozen, results 3 and 4 active-ce cycles after acceptance, no beat lost or duplicated.
- Reset mid-group: two accumulate beats of 10×10, reset, then single beat 2×3 with last → dout=6.

Source files
------------

// File: rtl/conv_mac_pkg.sv
// Shared constants and the result-conversion helper for the convolution MAC datapath.
package conv_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Widest value the conversion helper handles; callers size-cast in and out.
    localparam int CONV_W = 64;

    // Clamp val to an out_w-bit signed range when sat is set, else pass it through
    // so the caller's narrowing cast keeps the two's-complement LSBs.
    function automatic logic signed [CONV_W-1:0] sat_trunc(
        input logic signed [CONV_W-1:0] val,
        input int unsigned              out_w,
        input logic                     sat
    );
        logic signed [CONV_W-1:0] max_v;
        logic signed [CONV_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sat && (val > max_v)) begin
            return max_v;
        end
        if (sat && (val < min_v)) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/conv_mac_mul_pipe.sv
// Signed multiplier with operand registers and a NUM_STAGE product chain; valid/mode/last
// ride alongside. Data registers carry no reset so the chain can be absorbed into a DSP.
module conv_mac_mul_pipe #(
    parameter int NUM_STAGE = 2,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ce,
    input  logic                                in_valid,
    input  logic                                in_mode,
    input  logic                                in_last,
    input  logic signed [A_WIDTH-1:0]           din0,
    input  logic signed [B_WIDTH-1:0]           din1,
    output logic                                p_valid,
    output logic                                p_mode,
    output logic                                p_last,
    output logic signed [A_WIDTH+B_WIDTH-1:0]   p_data
);
    localparam int P_W = A_WIDTH + B_WIDTH;

    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic [2:0]                side_q;
    logic signed [P_W-1:0]     prod_d;
    logic signed [P_W-1:0]     prod_q  [NUM_STAGE];
    logic [2:0]                pside_q [NUM_STAGE];

    assign prod_d = a_q * b_q;

    always_ff @(posedge clk) begin
        if (ce) begin
            a_q       <= din0;
            b_q       <= din1;
            prod_q[0] <= prod_d;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Sideband {valid, mode, last}; only this needs reset to discard in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                pside_q[i] <= '0;
            end
        end else if (ce) begin
            side_q     <= {in_valid, in_mode, in_last};
            pside_q[0] <= side_q;
            for (int i = 1; i < NUM_STAGE; i++) begin
                pside_q[i] <= pside_q[i-1];
            end
        end
    end

    assign p_valid = pside_q[NUM_STAGE-1][2];
    assign p_mode  = pside_q[NUM_STAGE-1][1];
    assign p_last  = pside_q[NUM_STAGE-1][0];
    assign p_data  = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate: product pipe, group accumulator,
// saturating or truncating output conversion, registered result.
module conv_mac_pipe
    import conv_mac_pkg::*;
#(
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int dout_WIDTH = 24,
    parameter int SATURATE   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         in_mode,
    input  logic                         in_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         out_valid,
    output logic signed [dout_WIDTH-1:0] dout
);
    localparam int P_W = din0_WIDTH + din1_WIDTH;

    logic                         p_valid;
    logic                         p_mode;
    logic                         p_last;
    logic signed [P_W-1:0]        p_data;

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [dout_WIDTH-1:0] dout_q, dout_d;
    logic signed [ACC_WIDTH-1:0]  p_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  result;

    conv_mac_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .A_WIDTH   (din0_WIDTH),
        .B_WIDTH   (din1_WIDTH)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .p_valid  (p_valid),
        .p_mode   (p_mode),
        .p_last   (p_last),
        .p_data   (p_data)
    );

    always_comb begin
        p_ext       = ACC_WIDTH'(p_data);
        sum         = acc_q + p_ext;
        result      = p_ext;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        dout_d      = dout_q;
        if (p_valid) begin
            if (p_mode == MODE_MUL) begin
                out_valid_d = 1'b1;
            end else if (p_last) begin
                result      = sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum;
            end
        end
        // Saturation only ever applies here; the accumulator itself wraps.
        if (out_valid_d) begin
            dout_d = dout_WIDTH'(sat_trunc(CONV_W'(result), dout_WIDTH, SATURATE != 0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else if (ce) begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench: truncating and saturating instances share stimulus; expected values hand-computed.
module tb_conv_mac_pipe;
    import conv_mac_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_mode = 1'b0;
    logic               in_last = 1'b0;
    logic signed [15:0] din0 = '0;
    logic signed [7:0]  din1 = '0;
    logic               ov_t, ov_s;
    logic signed [23:0] dout_t, dout_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_mac_pipe #(.SATURATE(0)) u_trunc (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_mode(in_mode),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_t), .dout(dout_t)
    );

    conv_mac_pipe #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_mode(in_mode),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_s), .dout(dout_s)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic l, input int a, input int b);
        in_valid = 1'b1;
        in_mode  = m;
        in_last  = l;
        din0     = 16'(a);
        din1     = 8'(b);
        tick();
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic ev, input longint et, input longint es);
        check_val({tag, ".vld_t"}, longint'(ov_t), longint'(ev));
        check_val({tag, ".vld_s"}, longint'(ov_s), longint'(ev));
        if (ev) begin
            check_val({tag, ".dout_t"}, dout_t, et);
            check_val({tag, ".dout_s"}, dout_s, es);
        end
    endtask

    initial begin
        tick();
        tick();
        chk_out("reset", 1'b0, 0, 0);
        check_val("reset.dout_t", dout_t, 0);
        check_val("reset.dout_s", dout_s, 0);
        reset = 1'b0;

        // Plain multiply, back to back; result 3 edges after acceptance.
        beat(MODE_MUL, 1'b0, -32768, -128);
        beat(MODE_MUL, 1'b0, 32767, 127);
        tick();  chk_out("mul.early", 1'b0, 0, 0);
        tick();  chk_out("mul.first", 1'b1, 4194304, 4194304);
        tick();  chk_out("mul.b2b", 1'b1, 4161409, 4161409);
        tick();  chk_out("mul.gap", 1'b0, 0, 0);

        // Accumulate group of four with a multiply beat interleaved.
        beat(MODE_ACC, 1'b0, 1000, 100);
        beat(MODE_ACC, 1'b0, 1000, 100);
        beat(MODE_MUL, 1'b0, 7, -3);
        beat(MODE_ACC, 1'b0, 1000, 100);
        beat(MODE_ACC, 1'b1, 1000, 100);
        chk_out("acc.open", 1'b0, 0, 0);
        tick();  chk_out("acc.mul", 1'b1, -21, -21);
        tick();  chk_out("acc.quiet", 1'b0, 0, 0);
        tick();  chk_out("acc.group", 1'b1, 400000, 400000);
        tick();  chk_out("acc.after", 1'b0, 0, 0);

        // Positive overflow of dout range.
        beat(MODE_ACC, 1'b0, 32767, 127);
        beat(MODE_ACC, 1'b0, 32767, 127);
        beat(MODE_ACC, 1'b1, 32767, 127);
        tick();  tick();  chk_out("satp.wait", 1'b0, 0, 0);
        tick();  chk_out("satp", 1'b1, -4292989, 8388607);

        // Negative overflow of dout range.
        beat(MODE_ACC, 1'b0, -32768, 127);
        beat(MODE_ACC, 1'b0, -32768, 127);
        beat(MODE_ACC, 1'b1, -32768, 127);
        tick();  tick();  chk_out("satn.wait", 1'b0, 0, 0);
        tick();  chk_out("satn", 1'b1, 4292608, -8388608);

        // Single-beat group.
        beat(MODE_ACC, 1'b1, -5, 7);
        tick();  tick();
        tick();  chk_out("single", 1'b1, -35, -35);

        // Stall with two beats in flight; beats offered during stall must be ignored.
        beat(MODE_MUL, 1'b0, 3, 5);
        beat(MODE_MUL, 1'b0, -4, 6);
        ce = 1'b0;
        in_valid = 1'b1;
        din0 = 16'sd9;
        din1 = 8'sd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall.vld", longint'(ov_t), 0);
            check_val("stall.dout", dout_t, -35);
        end
        in_valid = 1'b0;
        ce = 1'b1;
        tick();  chk_out("stall.resume", 1'b0, 0, 0);
        tick();  chk_out("stall.r1", 1'b1, 15, 15);
        ce = 1'b0;
        in_valid = 1'b1;
        tick();  tick();
        chk_out("stall.hold", 1'b1, 15, 15);
        in_valid = 1'b0;
        ce = 1'b1;
        tick();  chk_out("stall.r2", 1'b1, -24, -24);
        tick();  chk_out("stall.end", 1'b0, 0, 0);
        tick();  chk_out("stall.nodup", 1'b0, 0, 0);

        // Asynchronous reset with an open group and a result on dout.
        beat(MODE_MUL, 1'b0, 5, 5);
        beat(MODE_ACC, 1'b0, 10, 10);
        beat(MODE_ACC, 1'b0, 10, 10);
        tick();  chk_out("rst.pre", 1'b1, 25, 25);
        tick();  tick();
        #2 reset = 1'b1;
        #1;
        check_val("rst.async.vld", longint'(ov_t), 0);
        check_val("rst.async.dout_t", dout_t, 0);
        check_val("rst.async.dout_s", dout_s, 0);
        tick();
        reset = 1'b0;
        beat(MODE_ACC, 1'b1, 2, 3);
        tick();  chk_out("rst.nostale1", 1'b0, 0, 0);
        tick();  chk_out("rst.nostale2", 1'b0, 0, 0);
        tick();  chk_out("rst.group", 1'b1, 6, 6);
        tick();  chk_out("rst.after", 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
